uart_tx: RTL

Serial transmitter half of the TramelBlaze UART. It accepts a byte from the processor's output port on a load strobe and frames it as: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit. It then shifts the frame out on the tx line at the programmed bit period. Frame format controls are the same ones the receive side uses, so a loopback of tx into the receiver decodes with no errors.

---
 rtl/uart_tx.sv | 94 +++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Serial transmitter: frames a byte as start, 7/8 data bits LSB first,
// optional parity and one stop bit, then shifts it out at the programmed bit period.
module uart_tx (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] bit_period,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic        load,
  input  logic [7:0]  data,
  output logic        tx,
  output logic        tx_rdy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [18:0] bt_cnt;
  logic [18:0] bp_eff;
  logic [3:0]  bit_cnt;
  logic [3:0]  last_bit;
  logic [10:0] sr;
  logic [10:0] frame;
  logic [7:0]  dbits;
  logic        eight_q, pen_q;
  logic        accept, btu, done, par;

  // Gating on tx_rdy makes a held-high load start exactly one frame per idle slot.
  assign accept   = load & tx_rdy;
  assign bp_eff   = (bit_period < 19'd2) ? 19'd2 : bit_period;
  assign btu      = (state == SEND) && (bt_cnt == bp_eff - 19'd1);
  assign last_bit = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
  assign done     = btu && (bit_cnt == last_bit);

  assign dbits = {data[7] & eight, data[6:0]};
  assign par   = ohel ? ~^dbits : ^dbits;

  // Bits above the stop bit are filled with 1 so short frames need no special case.
  always_comb begin
    frame = '1;
    case ({eight, pen})
      2'b11:   frame = {1'b1, par, data, 1'b0};
      2'b10:   frame = {2'b11, data, 1'b0};
      2'b01:   frame = {2'b11, par, data[6:0], 1'b0};
      default: frame = {3'b111, data[6:0], 1'b0};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_rdy  <= 1'b1;
      bt_cnt  <= '0;
      bit_cnt <= '0;
      sr      <= '1;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
    end else if (accept) begin
      sr      <= frame;
      tx      <= 1'b0;
      tx_rdy  <= 1'b0;
      bt_cnt  <= '0;
      bit_cnt <= '0;
      eight_q <= eight;
      pen_q   <= pen;
    end else if (state == SEND) begin
      if (btu) begin
        bt_cnt  <= '0;
        sr      <= {1'b1, sr[10:1]};
        tx      <= done ? 1'b1 : sr[1];
        bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
        if (done) tx_rdy <= 1'b1;
      end else begin
        bt_cnt <= bt_cnt + 19'd1;
      end
    end
  end

endmodule
